// File: rtl/demux_dispatch_ctrl_if.sv
// Handshake and demux-side bundle for the dispatch controller.
// The master side is upstream plus destinations; the slave side is the controller.
interface demux_dispatch_ctrl_if #(
  parameter int unsigned BITS = 3
);
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] in_data;
  logic [2:0]      in_dest;
  logic            in_bcast;
  logic [7:0]      mask;
  logic [7:0]      dest_ready;
  logic [2:0]      sel;
  logic [BITS-1:0] data_out;
  logic [7:0]      we;
  logic            drop;
  logic            busy;

  modport master (
    output in_valid, in_data, in_dest, in_bcast, mask, dest_ready,
    input  in_ready, sel, data_out, we, drop, busy
  );

  modport slave (
    input  in_valid, in_data, in_dest, in_bcast, mask, dest_ready,
    output in_ready, sel, data_out, we, drop, busy
  );
endinterface

// File: rtl/demux_dispatch_ctrl.sv
// Dispatch sequencer for the 1-to-8 demux: accepts one word, then strobes it into one
// destination (unicast) or each masked destination in ascending order (broadcast).
//
// state  | meaning
// IDLE   | in_ready high, waiting for a word
// WAIT   | word latched, waiting for dest_ready[sel] or timeout
// WRITE  | we[sel] high for one cycle
// SKIP   | delivery timed out, drop high for one cycle
module demux_dispatch_ctrl #(
  parameter int unsigned BITS    = 3,
  parameter int unsigned TIMEOUT = 15
) (
  input logic               clock,
  input logic               reset,
  demux_dispatch_ctrl_if.slave bus
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2,
    S_SKIP  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [2:0]      sel_q, sel_nxt;
  logic [BITS-1:0] data_q, data_nxt;
  logic [7:0]      mask_q, mask_nxt;
  logic [CW-1:0]   cnt_q, cnt_nxt;
  logic [7:0]      above;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      sel_q  <= 3'd0;
      data_q <= '0;
      mask_q <= 8'd0;
      cnt_q  <= '0;
    end else begin
      state  <= state_nxt;
      sel_q  <= sel_nxt;
      data_q <= data_nxt;
      mask_q <= mask_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  // Channels still pending in a broadcast; sel=7 shifts everything out, so no wrap.
  assign above = mask_q & (8'hFE << sel_q);

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    data_nxt  = data_q;
    mask_nxt  = mask_q;
    cnt_nxt   = cnt_q;
    case (state)
      S_IDLE: begin
        if (bus.in_valid) begin
          data_nxt = bus.in_data;
          cnt_nxt  = '0;
          if (!bus.in_bcast) begin
            sel_nxt   = bus.in_dest;
            mask_nxt  = 8'd0;
            state_nxt = S_WAIT;
          end else if (bus.mask != 8'd0) begin
            sel_nxt   = lowest_set(bus.mask);
            mask_nxt  = bus.mask;
            state_nxt = S_WAIT;
          end else begin
            mask_nxt  = 8'd0;
          end
        end
      end
      S_WAIT: begin
        // Ready takes priority over a timeout landing on the same edge.
        if (bus.dest_ready[sel_q]) begin
          state_nxt = S_WRITE;
        end else if (TIMEOUT != 0) begin
          cnt_nxt = cnt_q + CW'(1);
          if (32'(cnt_nxt) == TIMEOUT) state_nxt = S_SKIP;
        end
      end
      S_WRITE, S_SKIP: begin
        if (above != 8'd0) begin
          sel_nxt   = lowest_set(above);
          cnt_nxt   = '0;
          state_nxt = S_WAIT;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.in_ready = (state == S_IDLE);
  assign bus.busy     = (state != S_IDLE);
  assign bus.we       = (state == S_WRITE) ? (8'b1 << sel_q) : 8'd0;
  assign bus.drop     = (state == S_SKIP);
  assign bus.sel      = sel_q;
  assign bus.data_out = data_q;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Scenario bench for demux_dispatch_ctrl: each task drives a scenario and checks timing,
// while a negedge monitor pops expected deliveries from a scoreboard queue.
module tb_demux_dispatch_ctrl;

  typedef struct packed {
    logic       drop;
    logic [2:0] ch;
    logic [2:0] data;
  } exp_t;

  logic clock;
  logic reset;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  exp_t sb[$];

  demux_dispatch_ctrl_if #(.BITS(3)) bus ();

  demux_dispatch_ctrl #(.BITS(3), .TIMEOUT(15)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Every strobe or drop must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && (bus.we != 8'd0 || bus.drop)) begin
      total_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected we=%b drop=%b sel=%0d required no delivery", bus.we, bus.drop, bus.sel);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.drop) begin
          if (bus.drop !== 1'b1 || bus.we !== 8'd0 || bus.sel !== e.ch)
            $display("FAIL sb_drop drop=%b we=%b sel=%0d required drop=1 we=0 sel=%0d", bus.drop, bus.we, bus.sel, e.ch);
          else pass_cnt++;
        end else begin
          if (bus.we !== (8'b1 << e.ch) || bus.drop !== 1'b0 || bus.data_out !== e.data)
            $display("FAIL sb_write we=%b drop=%b data=%0d required we=%b drop=0 data=%0d", bus.we, bus.drop, bus.data_out, 8'b1 << e.ch, e.data);
          else pass_cnt++;
        end
      end
    end
  end

  task automatic send(input logic [2:0] d, input logic [2:0] dst, input logic bc, input logic [7:0] m);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    total_cnt++;
    if (n >= 50) $display("FAIL send_ready in_ready=%b required 1", bus.in_ready);
    else pass_cnt++;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_dest  = dst;
    bus.in_bcast = bc;
    bus.mask     = m;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    total_cnt++;
    if (bus.sel !== 3'd0 || bus.data_out !== 3'd0 || bus.we !== 8'd0 || bus.drop !== 1'b0 ||
        bus.busy !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL reset_state sel=%0d data=%0d we=%b drop=%b busy=%b rdy=%b required 0 0 0 0 0 1",
               bus.sel, bus.data_out, bus.we, bus.drop, bus.busy, bus.in_ready);
    else pass_cnt++;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_unicast();
    bus.dest_ready = 8'hFF;
    sb.push_back('{drop: 1'b0, ch: 3'd6, data: 3'd5});
    bus.in_valid = 1'b1; bus.in_data = 3'd5; bus.in_dest = 3'd6; bus.in_bcast = 1'b0; bus.mask = 8'h00;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    total_cnt++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.sel !== 3'd6 || bus.data_out !== 3'd5 || bus.we !== 8'd0)
      $display("FAIL uni_c1 busy=%b rdy=%b sel=%0d data=%0d we=%b required 1 0 6 5 0",
               bus.busy, bus.in_ready, bus.sel, bus.data_out, bus.we);
    else pass_cnt++;
    @(posedge clock); #1;
    total_cnt++;
    if (bus.we !== 8'b0100_0000) $display("FAIL uni_c2_we we=%b required 01000000", bus.we);
    else pass_cnt++;
    @(posedge clock); #1;
    total_cnt++;
    if (bus.we !== 8'd0 || bus.in_ready !== 1'b1 || bus.sel !== 3'd6 || bus.data_out !== 3'd5)
      $display("FAIL uni_c3 we=%b rdy=%b sel=%0d data=%0d required 0 1 6 5", bus.we, bus.in_ready, bus.sel, bus.data_out);
    else pass_cnt++;
  endtask

  task automatic test_wait_ready();
    bus.dest_ready = 8'h00;
    sb.push_back('{drop: 1'b0, ch: 3'd2, data: 3'd4});
    send(3'd4, 3'd2, 1'b0, 8'h00);
    repeat (4) @(posedge clock);
    #1;
    total_cnt++;
    if (bus.busy !== 1'b1 || bus.we !== 8'd0 || bus.drop !== 1'b0)
      $display("FAIL wait_c5 busy=%b we=%b drop=%b required 1 0 0", bus.busy, bus.we, bus.drop);
    else pass_cnt++;
    bus.dest_ready = 8'b0000_0100;
    @(posedge clock); #1;
    total_cnt++;
    if (bus.we !== 8'b0000_0100 || bus.drop !== 1'b0) $display("FAIL wait_c6_we we=%b drop=%b required 00000100 0", bus.we, bus.drop);
    else pass_cnt++;
    @(posedge clock); #1;
    total_cnt++;
    if (bus.in_ready !== 1'b1 || bus.we !== 8'd0) $display("FAIL wait_idle rdy=%b we=%b required 1 0", bus.in_ready, bus.we);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int c;
    bus.dest_ready = 8'h00;
    sb.push_back('{drop: 1'b1, ch: 3'd3, data: 3'd7});
    send(3'd7, 3'd3, 1'b0, 8'h00);
    c = 1;
    while (c < 40 && bus.drop !== 1'b1) begin
      @(posedge clock); #1;
      c++;
    end
    total_cnt++;
    if (c != 16) $display("FAIL timeout_cycle drop_cycle=%0d required 16", c);
    else pass_cnt++;
    @(posedge clock); #1;
    total_cnt++;
    if (bus.in_ready !== 1'b1 || bus.drop !== 1'b0) $display("FAIL timeout_idle rdy=%b drop=%b required 1 0", bus.in_ready, bus.drop);
    else pass_cnt++;
  endtask

  task automatic test_broadcast();
    logic [7:0] we_at [1:10];
    logic       rdy_at [1:10];
    bus.dest_ready = 8'hFF;
    sb.push_back('{drop: 1'b0, ch: 3'd0, data: 3'd3});
    sb.push_back('{drop: 1'b0, ch: 3'd2, data: 3'd3});
    sb.push_back('{drop: 1'b0, ch: 3'd7, data: 3'd3});
    send(3'd3, 3'd5, 1'b1, 8'b1000_0101);
    for (int c = 1; c <= 10; c++) begin
      we_at[c]  = bus.we;
      rdy_at[c] = bus.in_ready;
      if (c < 10) begin @(posedge clock); #1; end
    end
    total_cnt++;
    if (we_at[2] !== 8'h01 || we_at[4] !== 8'h04 || we_at[6] !== 8'h80)
      $display("FAIL bcast_order c2=%b c4=%b c6=%b required 00000001 00000100 10000000", we_at[2], we_at[4], we_at[6]);
    else pass_cnt++;
    total_cnt++;
    if (we_at[1] !== 8'd0 || we_at[3] !== 8'd0 || we_at[5] !== 8'd0 || we_at[7] !== 8'd0)
      $display("FAIL bcast_gaps c1=%b c3=%b c5=%b c7=%b required all 0", we_at[1], we_at[3], we_at[5], we_at[7]);
    else pass_cnt++;
    total_cnt++;
    if (rdy_at[6] !== 1'b0 || rdy_at[7] !== 1'b1) $display("FAIL bcast_idle rdy6=%b rdy7=%b required 0 1", rdy_at[6], rdy_at[7]);
    else pass_cnt++;
  endtask

  task automatic test_bcast_skip();
    int c, drop_c, we_c;
    bus.dest_ready = 8'b1111_1101;
    sb.push_back('{drop: 1'b1, ch: 3'd1, data: 3'd6});
    sb.push_back('{drop: 1'b0, ch: 3'd2, data: 3'd6});
    send(3'd6, 3'd0, 1'b1, 8'b0000_0110);
    c = 1; drop_c = 0; we_c = 0;
    while (c < 40 && bus.in_ready !== 1'b1) begin
      if (bus.drop === 1'b1 && drop_c == 0) drop_c = c;
      if (bus.we === 8'b0000_0100 && we_c == 0) we_c = c;
      @(posedge clock); #1;
      c++;
    end
    total_cnt++;
    if (drop_c != 16 || we_c != 18 || c != 19)
      $display("FAIL bskip_timing drop=%0d we=%0d idle=%0d required 16 18 19", drop_c, we_c, c);
    else pass_cnt++;
  endtask

  task automatic test_bcast_zero();
    int bad;
    bus.dest_ready = 8'hFF;
    bus.in_valid = 1'b1; bus.in_data = 3'd2; bus.in_dest = 3'd4; bus.in_bcast = 1'b1; bus.mask = 8'h00;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    bad = 0;
    for (int c = 1; c <= 5; c++) begin
      if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.we !== 8'd0 || bus.drop !== 1'b0) bad++;
      @(posedge clock); #1;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL bzero_idle bad_cycles=%0d required 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] we_at [1:8];
    bus.dest_ready = 8'hFF;
    sb.push_back('{drop: 1'b0, ch: 3'd0, data: 3'd1});
    sb.push_back('{drop: 1'b0, ch: 3'd1, data: 3'd2});
    bus.in_valid = 1'b1; bus.in_data = 3'd1; bus.in_dest = 3'd0; bus.in_bcast = 1'b0; bus.mask = 8'hFF;
    @(posedge clock); #1;
    bus.in_data = 3'd2; bus.in_dest = 3'd1;
    for (int c = 1; c <= 8; c++) begin
      if (c == 4) bus.in_valid = 1'b0;
      we_at[c] = bus.we;
      if (c < 8) begin @(posedge clock); #1; end
    end
    total_cnt++;
    if (we_at[2] !== 8'h01 || we_at[5] !== 8'h02)
      $display("FAIL b2b_we c2=%b c5=%b required 00000001 00000010", we_at[2], we_at[5]);
    else pass_cnt++;
    total_cnt++;
    if (we_at[3] !== 8'd0 || we_at[4] !== 8'd0 || we_at[6] !== 8'd0 || we_at[7] !== 8'd0 || we_at[8] !== 8'd0)
      $display("FAIL b2b_extra c3=%b c4=%b c6=%b c7=%b c8=%b required all 0", we_at[3], we_at[4], we_at[6], we_at[7], we_at[8]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_wait();
    bus.dest_ready = 8'h00;
    send(3'd5, 3'd3, 1'b0, 8'h00);
    @(posedge clock); #3;
    total_cnt++;
    if (bus.busy !== 1'b1) $display("FAIL rst_pre busy=%b required 1", bus.busy);
    else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (bus.sel !== 3'd0 || bus.data_out !== 3'd0 || bus.we !== 8'd0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL rst_async sel=%0d data=%0d we=%b busy=%b rdy=%b required 0 0 0 0 1",
               bus.sel, bus.data_out, bus.we, bus.busy, bus.in_ready);
    else pass_cnt++;
    reset = 1'b0;
    @(posedge clock); #1;
    total_cnt++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) $display("FAIL rst_after rdy=%b busy=%b required 1 0", bus.in_ready, bus.busy);
    else pass_cnt++;
  endtask

  initial begin
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = 3'd0;
    bus.in_dest    = 3'd0;
    bus.in_bcast   = 1'b0;
    bus.mask       = 8'h00;
    bus.dest_ready = 8'h00;
    test_reset();
    test_unicast();
    test_wait_ready();
    test_timeout();
    test_broadcast();
    test_bcast_skip();
    test_bcast_zero();
    test_back_to_back();
    test_reset_mid_wait();
    repeat (2) @(posedge clock);
    #1;
    total_cnt++;
    if (sb.size() != 0) $display("FAIL sb_drained pending=%0d required 0", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
